// File: rtl/regfile_scoreboard.sv
// XLEN-wide register file with NRD combinational read ports, ALU and load writeback,
// and a per-register busy scoreboard for outstanding loads. Optional macro: REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*XLEN-1:0]   rd_data,
  input  logic                  wb_en,
  input  logic [AW-1:0]         wb_addr,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  ld_issue,
  input  logic [AW-1:0]         ld_issue_addr,
  input  logic                  ld_done,
  input  logic [AW-1:0]         ld_addr,
  input  logic [XLEN-1:0]       ld_data,
  input  logic [NRD-1:0]        rd_use,
  output logic                  stall,
  output logic [AW:0]           busy_cnt
);

  logic [NREG-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREG-1:0]           busy_q, busy_d;
  logic [AW:0]               busy_cnt_q, busy_cnt_d;

  function automatic logic [AW:0] count_busy(input logic [NREG-1:0] b);
    logic [AW:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) c = c + (AW+1)'(b[i]);
    return c;
  endfunction

  // Next state: load data is applied after ALU data so it wins on a shared target;
  // a same-cycle issue re-marks the register busy after the completing load clears it.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wb_en && wb_addr != '0) regs_d[wb_addr] = wb_data;
    if (ld_done && ld_addr != '0) begin
      regs_d[ld_addr] = ld_data;
      busy_d[ld_addr] = 1'b0;
    end
    if (ld_issue && ld_issue_addr != '0) busy_d[ld_issue_addr] = 1'b1;
    regs_d[0]  = '0;
    busy_d[0]  = 1'b0;
    busy_cnt_d = count_busy(busy_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q     <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  // Read ports and hazard detection, both purely combinational.
  always_comb begin
    logic [AW-1:0]   rd_a;
    logic [XLEN-1:0] val;
    logic            hit;
    rd_data = '0;
    stall   = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      rd_a = rd_addr[k*AW +: AW];
      val  = regs_q[rd_a];
      hit  = rd_use[k] && busy_q[rd_a] && (rd_a != '0);
`ifdef REGFILE_BYPASS_EN
      if (wb_en && wb_addr == rd_a) val = wb_data;
      if (ld_done && ld_addr == rd_a) begin
        val = ld_data;
        hit = 1'b0;
      end
`else
`endif
      if (rd_a == '0) val = '0;
      rd_data[k*XLEN +: XLEN] = val;
      stall = stall | hit;
    end
    if (wb_en && busy_q[wb_addr] && wb_addr != '0) stall = 1'b1;
    if (ld_issue && busy_q[ld_issue_addr] && ld_issue_addr != '0) stall = 1'b1;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the core's flat 64-bit register array: an XLEN-wide integer register file with NRD combinational read ports.
- Has two write ports: ALU/jump writeback, plus a late-arriving load writeback.
- Per-register busy scoreboard lets the core issue a load and keep running while the data memory is slow.
- Raises a stall request when a read or write hits a register whose load is still outstanding. Sits between decode and the ALU in the next core generation.

Parameters:
- XLEN, 64, register width in bits.
- NREG, 32, number of architectural registers (power of two, >=2); register 0 hardwired to zero.
- NRD, 2, number of read ports.
- AW, $clog2(NREG), register address width (derived, not overridden).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- rd_addr  input  NRD*AW  read addresses; port k at bits [k*AW +: AW].
- rd_data  output  NRD*XLEN  read data; port k at bits [k*XLEN +: XLEN].
- wb_en  input  1  ALU/jump writeback enable.
- wb_addr  input  AW  ALU writeback destination.
- wb_data  input  XLEN  ALU writeback value.
- ld_issue  input  1  load issued this cycle; marks ld_issue_addr busy.
- ld_issue_addr  input  AW  load destination register.
- ld_done  input  1  load data returning this cycle.
- ld_addr  input  AW  returning load destination.
- ld_data  input  XLEN  returning load value.
- rd_use  input  NRD  port k's value is actually consumed this cycle.
- stall  output  1  hazard on a busy register; core must hold its issue.
- busy_cnt  output  AW+1  number of registers currently busy.

Behaviour:
- Reset (rst=1 at a rising edge): all registers 0, all busy bits 0, busy_cnt 0, stall 0. Applies even with a load outstanding; a ld_done arriving in the same cycle is discarded.
- Reads are combinational. rd_data[k] = reg[rd_addr[k]], and reads 0 when rd_addr[k]==0.
- Writes commit on the rising edge. Address 0 is never written and never marked busy.
- Same-cycle wb and ld to the same nonzero address: ld_data wins. Case is legal only if wb_en is from an older instruction.
- Scoreboard, one busy bit per register:
  - ld_issue with address !=0 sets busy next cycle.
  - ld_done clears busy for ld_addr next cycle and writes ld_data.
  - ld_issue and ld_done to the same address in one cycle: busy stays 1 (new load outstanding); data is still written.
  - ld_done to a non-busy register: data written, busy unchanged (0). Legal, no error.
  - ld_issue to an already-busy register: busy stays 1. At most one load per register is in flight; core guarantees this by stalling.
- stall = OR over k of (rd_use[k] & busy[rd_addr[k]] & rd_addr[k]!=0), OR (wb_en & busy[wb_addr] & wb_addr!=0), OR (ld_issue & busy[ld_issue_addr] & ld_issue_addr!=0). Purely combinational from current state and inputs.
- While stall=1, the block still accepts ld_done; the core must not assert wb_en/ld_issue for the stalled instruction. Any such writes presented are still performed (the block does not gate them).
- busy_cnt: registered popcount of busy bits, updated the same edge as busy. Range 0..NREG-1.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - A read whose address matches a same-cycle ld_done (priority) or wb_en target returns the incoming data combinationally.
  - A stall term from rd_use is suppressed when ld_done matches that rd_addr in the same cycle, saving one stall cycle per load-use.
- Undefined: reads see only committed state; the stall term stays asserted until the edge after ld_done.

Test Plan:
- Reset then read all ports, addr 1 and 31 -> rd_data 0, stall 0, busy_cnt 0. Then wb_en addr 5 data 0x1234 -> next cycle reading 5 returns 0x1234.
- wb_en to addr 0 with 0xFFFF_FFFF_FFFF_FFFF -> reading 0 still returns 0; ld_issue addr 0 -> busy_cnt stays 0, no stall.
- ld_issue addr 7; next cycle rd_addr[0]=7 with rd_use[0]=1 -> stall 1, busy_cnt 1. ld_done addr 7 data 0xABCD:
  - Without BYPASS_EN: stall holds that cycle, clears the next, read returns 0xABCD.
  - With BYPASS_EN: stall 0 and rd_data 0xABCD in the ld_done cycle.
- Same cycle wb_en addr 9 data 1 and ld_done addr 9 data 2 -> reg 9 reads 2.
- ld_issue addr 3 and ld_done addr 3 in same cycle with 3 busy -> busy stays 1, busy_cnt unchanged, reg 3 holds the returned data.
- Loads outstanding on regs 4,5,6 (busy_cnt 3), assert rst -> next cycle busy_cnt 0, all reads 0, stall 0; a ld_done during the rst cycle leaves its register 0.
